ofs_fim_eth_tx_pkt_arb: RTL and testbench

- Packet-level round-robin arbiter that shares one HSSI SS TX AXI-Stream channel (client -> HSSI SS) between NUM_PORTS requester streams.
- Sits between the AFU/host TX streams and a single Ethernet channel's TX port.
- Grants at packet boundaries only, so beats from different requesters never interleave within a packet.
- Registered output stage; per-port enable mask supplied by the CSR block.

---
 rtl/ofs_fim_eth_arb_pkg.sv | 30 +++
 rtl/ofs_fim_axis_skid_buf.sv | 70 +++++++
 rtl/ofs_fim_eth_tx_pkt_arb.sv | 110 +++++++++++
 tb/tb_ofs_fim_eth_tx_pkt_arb.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ofs_fim_eth_arb_pkg.sv
// Shared types and helpers for the ETH TX packet arbiter.
// Round-robin selection lives here so other arbiters can reuse it.
package ofs_fim_eth_arb_pkg;

  localparam int ARB_MAX_PORTS  = 8;
  localparam int ETH_PACKET_W   = 64;
  localparam int ETH_TX_TUSER_W = 1;

  typedef enum logic {
    ARB  = 1'b0,
    PASS = 1'b1
  } t_arb_state;

  // First set bit of req at or above ptr, wrapping. Requests above the real port
  // count must be zero, which makes the fixed-width wrap equal to the port-count wrap.
  function automatic logic [2:0] rr_pick(input logic [ARB_MAX_PORTS-1:0] req,
                                         input logic [2:0]               ptr);
    logic [2*ARB_MAX_PORTS-1:0] dbl;
    logic [ARB_MAX_PORTS-1:0]   rot;
    logic [2:0]                 off;
    dbl = {req, req} >> ptr;
    rot = dbl[ARB_MAX_PORTS-1:0];
    off = '0;
    for (int i = ARB_MAX_PORTS - 1; i >= 0; i--) begin
      if (rot[i]) off = 3'(i);
    end
    return ptr + off;
  endfunction

endpackage

// File: rtl/ofs_fim_axis_skid_buf.sv
// Two-entry AXIS skid buffer; output always comes from the head register.
// Full is derived from registered occupancy only, so it never depends on i_rd_ready.
module ofs_fim_axis_skid_buf
  import ofs_fim_eth_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_valid,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_full,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_head, r_skid, w_head_nxt, w_skid_nxt;
  logic [1:0]       r_cnt, w_cnt_nxt;
  logic             w_rd;

  assign w_rd       = (r_cnt != 2'd0) && i_rd_ready;
  assign o_full     = (r_cnt == 2'd2);
  assign o_rd_valid = (r_cnt != 2'd0);
  assign o_rd_data  = r_head;

  always_comb begin
    w_head_nxt = r_head;
    w_skid_nxt = r_skid;
    w_cnt_nxt  = r_cnt;
    case (r_cnt)
      2'd0: begin
        if (i_wr_valid) begin
          w_head_nxt = i_wr_data;
          w_cnt_nxt  = 2'd1;
        end
      end
      2'd1: begin
        if (i_wr_valid && w_rd) begin
          w_head_nxt = i_wr_data;
        end else if (i_wr_valid) begin
          w_skid_nxt = i_wr_data;
          w_cnt_nxt  = 2'd2;
        end else if (w_rd) begin
          w_cnt_nxt  = 2'd0;
        end
      end
      2'd2: begin
        if (w_rd) begin
          w_head_nxt = r_skid;
          w_cnt_nxt  = 2'd1;
        end
      end
      default: w_cnt_nxt = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_skid <= '0;
      r_cnt  <= 2'd0;
    end else begin
      r_head <= w_head_nxt;
      r_skid <= w_skid_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/ofs_fim_eth_tx_pkt_arb.sv
// Packet-level round-robin arbiter sharing one HSSI TX AXI-Stream channel.
// Grants only between packets; one bubble cycle per packet is spent in ARB.
module ofs_fim_eth_tx_pkt_arb
  import ofs_fim_eth_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = ETH_PACKET_W,
  parameter int TUSER_W   = ETH_TX_TUSER_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            i_port_en,
  input  logic [NUM_PORTS-1:0]            i_in_tvalid,
  output logic [NUM_PORTS-1:0]            o_in_tready,
  input  logic [NUM_PORTS-1:0]            i_in_tlast,
  input  logic [NUM_PORTS*DATA_W-1:0]     i_in_tdata,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0] i_in_tkeep,
  input  logic [NUM_PORTS*TUSER_W-1:0]    i_in_tuser,
  output logic                            o_out_tvalid,
  input  logic                            i_out_tready,
  output logic                            o_out_tlast,
  output logic [DATA_W-1:0]               o_out_tdata,
  output logic [DATA_W/8-1:0]             o_out_tkeep,
  output logic [TUSER_W-1:0]              o_out_tuser,
  output logic [$clog2(NUM_PORTS)-1:0]    o_grant,
  output logic                            o_busy,
  output logic                            o_pkt_done
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int GW     = $clog2(NUM_PORTS);
  localparam int PW     = DATA_W + KEEP_W + TUSER_W + 1;

  t_arb_state           r_state, w_state_nxt;
  logic [GW-1:0]        r_grant, w_grant_nxt, r_ptr, w_ptr_nxt;
  logic                 r_pkt_done, w_pkt_done_nxt;
  logic [NUM_PORTS-1:0] w_req;
  logic [2:0]           w_pick;
  logic                 w_full, w_wr;
  logic [PW-1:0]        w_wdata, w_rdata;

  assign w_req  = i_in_tvalid & i_port_en;
  assign w_pick = rr_pick(ARB_MAX_PORTS'(w_req), 3'(r_ptr));

  assign w_wdata = {i_in_tlast[r_grant],
                    i_in_tuser[r_grant*TUSER_W +: TUSER_W],
                    i_in_tkeep[r_grant*KEEP_W +: KEEP_W],
                    i_in_tdata[r_grant*DATA_W +: DATA_W]};

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_ptr_nxt      = r_ptr;
    w_pkt_done_nxt = 1'b0;
    w_wr           = 1'b0;
    o_in_tready    = '0;
    case (r_state)
      ARB: begin
        if (|w_req) begin
          w_grant_nxt = GW'(w_pick);
          w_state_nxt = PASS;
        end
      end
      PASS: begin
        // port_en is deliberately not consulted here: an open packet always completes
        o_in_tready[r_grant] = !w_full;
        w_wr                 = i_in_tvalid[r_grant] && !w_full;
        if (w_wr && i_in_tlast[r_grant]) begin
          w_pkt_done_nxt = 1'b1;
          w_ptr_nxt      = (r_grant == GW'(NUM_PORTS - 1)) ? '0 : r_grant + 1'b1;
          w_state_nxt    = ARB;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB;
      r_grant    <= '0;
      r_ptr      <= '0;
      r_pkt_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_ptr      <= w_ptr_nxt;
      r_pkt_done <= w_pkt_done_nxt;
    end
  end

  ofs_fim_axis_skid_buf #(
    .WIDTH (PW)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_valid (w_wr),
    .i_wr_data  (w_wdata),
    .o_full     (w_full),
    .o_rd_valid (o_out_tvalid),
    .i_rd_ready (i_out_tready),
    .o_rd_data  (w_rdata)
  );

  assign {o_out_tlast, o_out_tuser, o_out_tkeep, o_out_tdata} = w_rdata;
  assign o_grant    = r_grant;
  assign o_busy     = (r_state == PASS);
  assign o_pkt_done = r_pkt_done;

endmodule

// File: tb/tb_ofs_fim_eth_tx_pkt_arb.sv
// Bench for the ETH TX packet arbiter: table of traffic scenarios plus an async-reset sequence.
// Accepted input beats go into a scoreboard queue and are popped as output beats appear.
module tb_ofs_fim_eth_tx_pkt_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   port_en, in_tvalid, in_tready, in_tlast, in_tuser;
  logic [255:0] in_tdata;
  logic [31:0]  in_tkeep;
  logic         out_tvalid, out_tready, out_tlast, out_tuser;
  logic [63:0]  out_tdata;
  logic [7:0]   out_tkeep;
  logic [1:0]   grant;
  logic         busy, pkt_done;

  always #5 clk = ~clk;

  ofs_fim_eth_tx_pkt_arb #(
    .NUM_PORTS (4),
    .DATA_W    (64),
    .TUSER_W   (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_port_en    (port_en),
    .i_in_tvalid  (in_tvalid),
    .o_in_tready  (in_tready),
    .i_in_tlast   (in_tlast),
    .i_in_tdata   (in_tdata),
    .i_in_tkeep   (in_tkeep),
    .i_in_tuser   (in_tuser),
    .o_out_tvalid (out_tvalid),
    .i_out_tready (out_tready),
    .o_out_tlast  (out_tlast),
    .o_out_tdata  (out_tdata),
    .o_out_tkeep  (out_tkeep),
    .o_out_tuser  (out_tuser),
    .o_grant      (grant),
    .o_busy       (busy),
    .o_pkt_done   (pkt_done)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        u;
    logic        l;
  } beat_t;

  typedef struct {
    string           name;
    logic [3:0]      en;
    logic [3:0]      en_mid;     // port_en applied once the first beat is accepted
    logic [3:0]      act;        // ports that have traffic
    int              len;
    int              npk;
    bit              toggle;     // out_tready pattern 1,0,0,1 instead of held high
    int              nexp;
    logic [7:0][1:0] g;          // expected grant order, g[0] first
    int              max_occ;
    int              span;       // first-to-last output beat in cycles, 0 = unchecked
    logic [3:0]      rdy_mask;   // ports expected to ever see in_tready
  } vec_t;

  beat_t sb[$];
  int    errs   = 0;
  int    checks = 0;
  vec_t  vecs[6];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk_beat(input int p, input int pk, input int b, input int len);
    beat_t r;
    r.d = {16'hBEEF, 8'(p), 8'(pk), 24'h0, 8'(32'hA0 + b)};
    r.k = 8'(8'hFF >> (b % 8));
    r.u = 1'((b + p) % 2);
    r.l = (b == len - 1);
    return r;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    in_tvalid  = '0;
    in_tlast   = '0;
    out_tready = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input bit do_reset);
    int    pk[4];
    int    bt[4];
    int    outs, dones, ntl, first, last, occ, total;
    logic  [3:0] seen;
    bit    mid_done;
    beat_t b, e;
    if (do_reset) apply_reset();
    port_en = v.en;
    for (int p = 0; p < 4; p++) begin
      pk[p] = 0;
      bt[p] = 0;
    end
    outs = 0; dones = 0; ntl = 0; first = -1; last = -1; occ = 0;
    seen = '0; mid_done = 1'b0;
    total = v.nexp * v.len;
    for (int cyc = 0; cyc < 3000 && (outs < total || dones < v.nexp); cyc++) begin
      @(negedge clk);
      out_tready = v.toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      for (int p = 0; p < 4; p++) begin
        b = mk_beat(p, pk[p], bt[p], v.len);
        in_tvalid[p]         = v.act[p] && (pk[p] < v.npk);
        in_tlast[p]          = b.l;
        in_tdata[p*64 +: 64] = b.d;
        in_tkeep[p*8 +: 8]   = b.k;
        in_tuser[p]          = b.u;
      end
      #1;
      seen |= in_tready;
      if (out_tvalid && out_tready) begin
        if (sb.size() == 0) begin
          chk({v.name, " spurious_beat"}, {out_tdata, out_tkeep, out_tuser, out_tlast}, '0);
        end else begin
          e = sb.pop_front();
          chk({v.name, " beat"}, {out_tdata, out_tkeep, out_tuser, out_tlast}, e);
        end
        if (first < 0) first = cyc;
        last = cyc;
        outs++;
        if (out_tlast && ntl < 8) begin
          chk({v.name, " out_pkt_port"}, out_tdata[47:40], v.g[ntl]);
          ntl++;
        end
      end
      if (pkt_done) begin
        if (dones < 8) chk({v.name, " grant"}, grant, v.g[dones]);
        dones++;
      end
      for (int p = 0; p < 4; p++) begin
        if (in_tvalid[p] && in_tready[p]) begin
          sb.push_back(mk_beat(p, pk[p], bt[p], v.len));
          if (bt[p] == v.len - 1) begin
            bt[p] = 0;
            pk[p]++;
          end else begin
            bt[p]++;
          end
          if (!mid_done) begin
            port_en  = v.en_mid;
            mid_done = 1'b1;
          end
        end
      end
      if (sb.size() > occ) occ = sb.size();
    end
    chk({v.name, " out_beats"}, outs, total);
    chk({v.name, " pkt_dones"}, dones, v.nexp);
    chk({v.name, " max_occ"}, occ, v.max_occ);
    if (v.span != 0) chk({v.name, " span"}, last - first + 1, v.span);
    chk({v.name, " ready_seen"}, seen, v.rdy_mask);
    chk({v.name, " sb_left"}, sb.size(), 0);
  endtask

  task automatic async_reset_seq();
    int acc;
    apply_reset();
    port_en            = 4'hF;
    out_tready         = 1'b0;
    in_tvalid          = 4'b0010;
    in_tlast           = '0;
    in_tdata[64 +: 64] = 64'h1234;
    acc = 0;
    for (int c = 0; c < 20 && acc < 2; c++) begin
      @(negedge clk);
      #1;
      if (in_tvalid[1] && in_tready[1]) acc++;
    end
    chk("prefill_beats", acc, 2);
    @(posedge clk);
    #2;
    chk("full_in_tready", in_tready, 4'b0000);
    chk("full_out_tvalid", out_tvalid, 1'b1);
    chk("full_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_tvalid", out_tvalid, 1'b0);
    chk("arst_in_tready", in_tready, 4'b0000);
    chk("arst_busy", busy, 1'b0);
    @(negedge clk);
    in_tvalid = '0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"rr4", 4'hF, 4'hF, 4'hF, 3, 2, 1'b0, 8,
                {2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0}, 1, 31, 4'hF};
    vecs[1] = '{"solo2", 4'hF, 4'hF, 4'b0100, 1, 5, 1'b0, 5,
                {2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2}, 1, 9, 4'b0100};
    vecs[2] = '{"mask", 4'b1011, 4'b1011, 4'hF, 2, 2, 1'b0, 6,
                {2'd0, 2'd0, 2'd3, 2'd1, 2'd0, 2'd3, 2'd1, 2'd0}, 1, 17, 4'b1011};
    vecs[3] = '{"bp", 4'hF, 4'hF, 4'b0010, 8, 1, 1'b1, 1,
                {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1}, 2, 0, 4'b0010};
    vecs[4] = '{"en_drop", 4'hF, 4'b1110, 4'b0011, 4, 2, 1'b0, 3,
                {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0}, 1, 14, 4'b0011};
    vecs[5] = '{"wrap", 4'hF, 4'hF, 4'b1001, 2, 2, 1'b0, 4,
                {2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0}, 1, 11, 4'b1001};

    port_en    = 4'hF;
    in_tvalid  = 4'hF;
    in_tlast   = '0;
    in_tdata   = '0;
    in_tkeep   = '0;
    in_tuser   = '0;
    out_tready = 1'b1;
    rst_n      = 1'b0;
    #1;
    chk("rst_out_tvalid", out_tvalid, 1'b0);
    chk("rst_in_tready", in_tready, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pkt_done", pkt_done, 1'b0);
    chk("rst_grant", grant, 2'd0);
    repeat (2) @(negedge clk);
    chk("rst_hold_in_tready", in_tready, 4'b0000);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b1);
    // After an async reset mid-packet the pointer must be back at 0: wrap starts with port 0
    async_reset_seq();
    run_vec(vecs[5], 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
